// File: rtl/morse_letter_decoder.sv
// rtl/morse_letter_decoder.sv - Morse A-H letter decoder: key sync, mark/space timing, pattern lookup.
// Optional input debounce stage enabled by defining MORSE_DECODER_DEBOUNCE_EN.
module morse_letter_decoder #(
  parameter int unsigned UNIT_CYC   = 25000000,
  parameter int unsigned DASH_UNITS = 2,
  parameter int unsigned GAP_UNITS  = 3,
  parameter int unsigned DEB_CYC    = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       key_n,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic [2:0] sym_count,
  output logic       mark_on
);

  localparam int unsigned DASH_CYC = DASH_UNITS * UNIT_CYC;
  localparam int unsigned GAP_CYC  = GAP_UNITS * UNIT_CYC;
  localparam int unsigned DUR_MAX  = ((DASH_CYC > GAP_CYC) ? DASH_CYC : GAP_CYC) + 1;
  localparam int unsigned DUR_W    = $clog2(DUR_MAX + 1);
  // dur trails the level length by one: the edge cycle itself leaves dur at 0.
  localparam logic [DUR_W-1:0] DASH_TH = DUR_W'(DASH_CYC - 1);
  localparam logic [DUR_W-1:0] GAP_TH  = DUR_W'(GAP_CYC - 2);

  if (UNIT_CYC < 1 || GAP_CYC < 2 || DASH_CYC < 1 || DEB_CYC < 1) begin : g_param_check
    $error("morse_letter_decoder: timing parameters out of range");
  end

  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

  logic [1:0]       sync;
  logic             key;
  state_t           state, state_nx;
  logic [DUR_W-1:0] dur, dur_nx, dur_inc;
  logic [3:0]       pattern, pattern_nx;
  logic [2:0]       cnt_nx, letter_nx, code;
  logic             valid_nx, err_nx, hit, is_dash;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) sync <= 2'b11;
    else       sync <= {sync[0], key_n};
  end

`ifdef MORSE_DECODER_DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);
  logic [DEB_W-1:0] deb_cnt;
  logic             key_f;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      deb_cnt <= '0;
      key_f   <= 1'b0;
    end else if (~sync[1] == key_f) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
      deb_cnt <= '0;
      key_f   <= ~sync[1];
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign key = key_f;
`else
  assign key = ~sync[1];
`endif

  assign mark_on = key;
  assign dur_inc = (dur == '1) ? dur : dur + 1'b1;
  assign is_dash = (dur >= DASH_TH);

  always_comb begin
    hit  = 1'b1;
    code = 3'd0;
    case ({sym_count, pattern})
      {3'd2, 4'b0001}: code = 3'd0;
      {3'd4, 4'b1000}: code = 3'd1;
      {3'd4, 4'b1010}: code = 3'd2;
      {3'd3, 4'b0100}: code = 3'd3;
      {3'd1, 4'b0000}: code = 3'd4;
      {3'd4, 4'b0010}: code = 3'd5;
      {3'd3, 4'b0110}: code = 3'd6;
      {3'd4, 4'b0000}: code = 3'd7;
      default:         hit  = 1'b0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    dur_nx     = dur_inc;
    pattern_nx = pattern;
    cnt_nx     = sym_count;
    letter_nx  = letter;
    valid_nx   = 1'b0;
    err_nx     = 1'b0;
    case (state)
      IDLE: begin
        dur_nx = '0;
        if (key) state_nx = MARK;
      end
      MARK: begin
        if (!key) begin
          state_nx = SPACE;
          dur_nx   = '0;
          // A fifth symbol parks the count at 5, which doubles as the overflow flag.
          if (sym_count < 3'd4) begin
            pattern_nx = {pattern[2:0], is_dash};
            cnt_nx     = sym_count + 3'd1;
          end else begin
            cnt_nx = 3'd5;
          end
        end
      end
      SPACE: begin
        if (key) begin
          state_nx = MARK;
          dur_nx   = '0;
        end else if (dur >= GAP_TH) begin
          state_nx = EMIT;
        end
      end
      EMIT: begin
        dur_nx     = '0;
        pattern_nx = '0;
        cnt_nx     = 3'd0;
        if (hit) begin
          letter_nx = code;
          valid_nx  = 1'b1;
        end else begin
          err_nx = 1'b1;
        end
        state_nx = key ? MARK : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state        <= IDLE;
      dur          <= '0;
      pattern      <= '0;
      sym_count    <= 3'd0;
      letter       <= 3'd0;
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
    end else begin
      state        <= state_nx;
      dur          <= dur_nx;
      pattern      <= pattern_nx;
      sym_count    <= cnt_nx;
      letter       <= letter_nx;
      letter_valid <= valid_nx;
      letter_err   <= err_nx;
    end
  end

endmodule

// File: tb/tb_morse_letter_decoder.sv
// tb/tb_morse_letter_decoder.sv - scoreboard bench for morse_letter_decoder (UNIT_CYC=10, DASH=2, GAP=3).
module tb_morse_letter_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_n = 1'b1;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_err;
  logic [2:0] sym_count;
  logic       mark_on;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];
  logic [2:0] last_letter = 3'd0;

  always #5 clk = ~clk;

  morse_letter_decoder #(
    .UNIT_CYC  (10),
    .DASH_UNITS(2),
    .GAP_UNITS (3),
    .DEB_CYC   (4)
  ) dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .key_n       (key_n),
    .letter      (letter),
    .letter_valid(letter_valid),
    .letter_err  (letter_err),
    .sym_count   (sym_count),
    .mark_on     (mark_on)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Every output pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (letter_valid || letter_err) begin
      logic [3:0] e;
      check("pulse_exclusive", letter_valid & letter_err, 0);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_err", letter_err, e[3]);
        check("pulse_letter", letter, e[2:0]);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark(input int n);
    key_n = 1'b0;
    wait_cyc(n);
  endtask

  task automatic space(input int n);
    key_n = 1'b1;
    wait_cyc(n);
  endtask

  task automatic expect_letter(input logic [2:0] l);
    exp_q.push_back({1'b0, l});
    last_letter = l;
  endtask

  task automatic expect_err();
    exp_q.push_back({1'b1, last_letter});
  endtask

  // Marks of the final symbol and the final gap are given; sym_count is checked mid-gap.
  task automatic finish_letter(input string name, input int n_sym, input int gap);
    space(5);
    check({name, "_sym_count"}, sym_count, (n_sym > 4) ? 5 : n_sym);
    check({name, "_mark_off"}, mark_on, 0);
    space(gap - 5);
    space(12);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_count_cleared"}, sym_count, 0);
  endtask

  task automatic send_syms(input string name, input string syms);
    for (int i = 0; i < syms.len(); i++) begin
      if (i != 0) space(10);
      mark((syms[i] == "-") ? 30 : 10);
    end
    finish_letter(name, syms.len(), 40);
  endtask

  initial begin
    wait_cyc(3);
    check("rst_letter", letter, 0);
    check("rst_valid", letter_valid, 0);
    check("rst_err", letter_err, 0);
    check("rst_sym_count", sym_count, 0);
    check("rst_mark_on", mark_on, 0);
    rst = 1'b0;
    wait_cyc(5);

    // A: 10-cycle dot, 25-cycle dash.
    expect_letter(3'd0);
    mark(10);
    space(10);
    mark(5);
    check("a_mark_on", mark_on, 1);
    mark(20);
    finish_letter("a", 2, 40);

    expect_letter(3'd2);
    send_syms("c", "-.-.");
    expect_letter(3'd7);
    send_syms("h", "....");

    // Reset in the middle of a mark: no pulse, outputs back at reset values.
    mark(15);
    rst   = 1'b1;
    key_n = 1'b1;
    wait_cyc(1);
    check("midrst_letter", letter, 0);
    check("midrst_sym_count", sym_count, 0);
    check("midrst_mark_on", mark_on, 0);
    check("midrst_valid", letter_valid, 0);
    rst = 1'b0;
    last_letter = 3'd0;
    space(50);
    check("midrst_no_pulse", exp_q.size(), 0);

    // 19-cycle mark is a dot; 30-cycle space ends the letter.
    expect_letter(3'd4);
    mark(19);
    finish_letter("e19", 1, 30);

    // 20-cycle mark is a dash: T is not decodable, letter keeps E.
    expect_err();
    mark(20);
    finish_letter("t20", 1, 30);
    check("t20_letter_held", letter, 4);

    // Five dots overflow the pattern.
    expect_err();
    for (int i = 0; i < 5; i++) begin
      if (i != 0) space(10);
      mark(10);
    end
    finish_letter("ovf", 5, 40);
    check("ovf_letter_held", letter, 4);

    // A 29-cycle space stays inside the letter.
    expect_letter(3'd0);
    mark(10);
    space(29);
    mark(30);
    finish_letter("a_gap29", 2, 40);

    expect_letter(3'd3);
    send_syms("d", "-..");
    expect_letter(3'd6);
    send_syms("g", "--.");
    expect_letter(3'd1);
    send_syms("b", "-...");
    expect_letter(3'd5);
    send_syms("f", "..-.");

    check("final_letter", letter, 5);
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
